// File: rtl/ser_rx_pkg.sv
// ser_rx_pkg -- shared types and helpers for the ser_rx serial receiver.
//   state_t   : receiver FSM states (PARITY only reachable with SER_RX_PARITY_EN)
//   calc_div(): clocks per bit, rounded to nearest
package ser_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY,
        WAIT_IDLE
    } state_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/ser_rx_sync.sv
// ser_rx_sync -- two-flop synchronizer for an asynchronous level input.
// Ports:
//   i_clk   : sampling clock
//   i_reset : synchronous, active-high; both flops load RST_VAL
//   i_d     : asynchronous input
//   o_q     : synchronized output, 2-cycle latency
module ser_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ser_rx.sv
// ser_rx -- UART-style asynchronous receiver, 8 data bits, LSB first, 1 stop.
// Optional parity: define SER_RX_PARITY_EN to add a PARITY state, the ODD
// parameter and the parity_err output.
// Ports:
//   clk, reset  : clock; synchronous active-high reset
//   rxd         : asynchronous serial line, idle high
//   rx_data     : received byte, stable while rx_valid is high
//   rx_valid    : rx_data holds an unconsumed byte
//   rx_ready    : consumer takes the byte when rx_valid & rx_ready
//   frame_err   : sticky, stop bit sampled low
//   overrun_err : sticky, byte completed while the previous one was pending
//   err_clr     : one-cycle pulse clears the sticky flags (a set wins)
//   busy        : FSM not in IDLE
//   parity_err  : (SER_RX_PARITY_EN only) sticky, parity mismatch
module ser_rx
    import ser_rx_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
`ifdef SER_RX_PARITY_EN
    ,
    parameter bit ODD    = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    input  logic       err_clr,
    output logic       busy
`ifdef SER_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    // Half a bit to reach the middle of the start bit, then whole bits.
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    if (DIV < 4) begin : g_div_check
        $error("ser_rx: DIV = %0d clocks per bit, must be >= 4", DIV);
    end

`ifdef SER_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    logic          w_rxd_s;
    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_ovr;

    logic          w_tick;
    logic          w_busy;
    logic          w_load_half;
    logic          w_load_full;
    logic          w_shift;
    logic          w_done;
    logic          w_ferr_set;
    logic          w_par_bad;

    ser_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (rxd),
        .o_q     (w_rxd_s)
    );

    // The counter only ever reloads or counts down to zero; zero is the sample point.
    assign w_tick = (r_cnt == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (!w_rxd_s) w_next = START;
            START:     if (w_tick) w_next = w_rxd_s ? IDLE : DATA;
            DATA:      if (w_tick && r_idx == 3'd7) w_next = AFTER_DATA;
            PARITY:    if (w_tick) w_next = STOP;
            STOP:      if (w_tick) w_next = w_rxd_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (w_rxd_s) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        w_busy      = (r_state != IDLE);
        w_load_half = (r_state == IDLE) && !w_rxd_s;
        w_load_full = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_ferr_set  = 1'b0;
        if (w_tick) begin
            case (r_state)
                START:   w_load_full = !w_rxd_s;
                DATA:    begin w_load_full = 1'b1; w_shift = 1'b1; end
                PARITY:  w_load_full = 1'b1;
                STOP:    begin
                    w_done     = w_rxd_s && !w_par_bad;
                    w_ferr_set = !w_rxd_s;
                end
                default: ;
            endcase
        end
    end

    // ---------------- bit timing and deserialiser ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            if (w_load_half)            r_cnt <= HALF_LOAD;
            else if (w_load_full)       r_cnt <= FULL_LOAD;
            else if (w_busy && !w_tick) r_cnt <= r_cnt - 1'b1;

            if (r_state == START) r_idx <= '0;
            else if (w_shift)     r_idx <= r_idx + 1'b1;

            if (w_shift) r_shift[r_idx] <= w_rxd_s;
        end
    end

    // ---------------- handshake and sticky flags ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            // A completing byte may replace one being consumed in the same cycle.
            if (w_done && (!r_valid || rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end

            if (w_done && r_valid && !rx_ready) r_ovr <= 1'b1;
            else if (err_clr)                   r_ovr <= 1'b0;

            if (w_ferr_set)   r_ferr <= 1'b1;
            else if (err_clr) r_ferr <= 1'b0;
        end
    end

`ifdef SER_RX_PARITY_EN
    logic r_par_bad;
    logic r_perr;
    logic w_perr_set;

    // Expected parity bit: XOR of data for even parity, inverted for odd.
    assign w_perr_set = w_tick && (r_state == PARITY) && (w_rxd_s != ((^r_shift) ^ ODD));
    assign w_par_bad  = r_par_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (w_load_half)     r_par_bad <= 1'b0;
            else if (w_perr_set) r_par_bad <= 1'b1;

            if (w_perr_set)   r_perr <= 1'b1;
            else if (err_clr) r_perr <= 1'b0;
        end
    end

    assign parity_err = r_perr;
`else
    assign w_par_bad = 1'b0;
`endif

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign frame_err   = r_ferr;
    assign overrun_err = r_ovr;
    assign busy        = w_busy;

endmodule

// File: tb/tb_ser_rx.sv
// tb_ser_rx -- self-checking bench for ser_rx (CLK_HZ = 1600, BAUD = 100, DIV = 16).
// The whole stimulus (line, reset, ready, clear) is laid out in per-cycle arrays
// first; a sample-point model then derives per-cycle events, and one compare
// process checks every output every cycle. Literal checks pin key cycles.
module tb_ser_rx;

    localparam int  DIV  = 16;
    localparam int  HALF = DIV / 2;
    localparam bit  ODD  = 1'b0;
`ifdef SER_RX_PARITY_EN
    localparam int  STOP_K = 10;
`else
    localparam int  STOP_K = 9;
`endif
    localparam int  FL  = (STOP_K + 1) * DIV;           // frame length, cycles
    localparam int  LAT = 3 + HALF + STOP_K * DIV;      // line start -> rx_valid cycle
    localparam int  N   = 12000;

    logic       clk = 1'b0;
    logic       reset, rxd, rx_ready, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun_err, busy;
`ifdef SER_RX_PARITY_EN
    logic       parity_err;
`endif

    ser_rx #(
        .CLK_HZ(1600),
        .BAUD  (100)
`ifdef SER_RX_PARITY_EN
        ,
        .ODD   (ODD)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .err_clr    (err_clr),
        .busy       (busy)
`ifdef SER_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus per cycle (value present during cycle c, sampled at the next edge).
    bit         ln[N], rstv[N], rd[N], cl[N];
    // Model: events taking effect at the edge that starts cycle c, and busy per cycle.
    bit         ev_b[N], ev_f[N], ev_p[N], bz[N];
    logic [7:0] ev_d[N];
    // Observed DUT outputs per cycle.
    logic [7:0] ob_data[N];
    bit         ob_vld[N], ob_ovr[N], ob_ferr[N], ob_busy[N], ob_perr[N];

    int tests = 0;
    int fails = 0;

    int T1, T2, X, T4, H, T4b, T5, T6, T6b, TP, TP2, TR;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic frame(input int t, input logic [7:0] d, input bit stopb, input bit parb);
        for (int i = 0; i < DIV; i++) begin
            ln[t + i] = 1'b0;
            for (int b = 0; b < 8; b++) ln[t + (b + 1) * DIV + i] = d[b];
            if (STOP_K == 10) ln[t + 9 * DIV + i] = parb;
            ln[t + STOP_K * DIV + i] = stopb;
        end
    endtask

    // Synchronized line as seen during cycle c: two cycles late, forced high
    // for two cycles after a reset edge.
    function automatic bit rsv(input int c);
        if (c < 2) return 1'b1;
        if (rstv[c - 1] || rstv[c - 2]) return 1'b1;
        return ln[c - 2];
    endfunction

    task automatic build();
        for (int c = 0; c < N; c++) begin
            ln[c] = 1'b1; rstv[c] = 1'b0; rd[c] = 1'b1; cl[c] = 1'b0;
        end
        for (int c = 0; c < 5; c++) rstv[c] = 1'b1;
        T1 = 40;
        frame(T1, 8'hA5, 1'b1, ^8'hA5);
        T2 = T1 + FL + 60;
        frame(T2, 8'h3C, 1'b1, ^8'h3C);
        frame(T2 + FL, 8'hC3, 1'b1, ^8'hC3);
        X = T2 + 2 * FL + 40;
        for (int c = T2; c < X; c++) rd[c] = 1'b0;
        cl[X + 5] = 1'b1;
        T4 = X + 40;
        frame(T4, 8'h55, 1'b0, ^8'h55);
        H = T4 + FL + 40 * DIV;
        for (int c = T4 + FL; c < H; c++) ln[c] = 1'b0;
        T4b = H + 40;
        frame(T4b, 8'h0F, 1'b1, ^8'h0F);
        T5 = T4b + FL + 40;
        for (int c = T5; c < T5 + 5; c++) ln[c] = 1'b0;
        T6 = T5 + 60;
        frame(T6, 8'hFF, 1'b1, ^8'hFF);
        rstv[T6 + 5 * DIV] = 1'b1;
        T6b = T6 + FL + 40;
        frame(T6b, 8'h81, 1'b1, ^8'h81);
        TP  = T6b + FL + 40;
        TP2 = TP + FL + 40;
`ifdef SER_RX_PARITY_EN
        frame(TP, 8'h07, 1'b1, 1'b0);
        frame(TP2, 8'h07, 1'b1, 1'b1);
`endif
        TR = TP2 + FL + 100;
        begin
            int t;
            t = TR;
            while (t < N - 3 * FL) begin
                int k;
                k = $urandom_range(0, 9);
                if (k == 0) begin
                    int g;
                    g = $urandom_range(1, 6);
                    for (int i = 0; i < g; i++) ln[t + i] = 1'b0;
                    t += g + 20;
                end else begin
                    logic [7:0] d;
                    bit sb, pb;
                    d  = 8'($urandom);
                    sb = (k != 1);
                    pb = ^d;
                    if ($urandom_range(0, 7) == 0) pb = !pb;
                    frame(t, d, sb, pb);
                    t += FL;
                    if (!sb) begin
                        int h;
                        h = $urandom_range(0, 3 * DIV);
                        for (int i = 0; i < h; i++) ln[t + i] = 1'b0;
                        t += h;
                    end
                    t += $urandom_range(0, 30);
                end
            end
        end
        for (int b = TR; b < N; b += 100) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int c = b; c < b + 100 && c < N; c++) begin
                rd[c] = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
                cl[c] = ($urandom_range(0, 63) == 0);
            end
        end
    endtask

    // Walks the synchronized line at its sample points: detect a low, sample the
    // middle of each bit, decide the outcome, and cut the frame short on reset.
    task automatic run_model();
        int p;
        p = 1;
        while (p < N - 2 * FL) begin
            int s0, sp, ss, e, x, stop_at;
            logic [7:0] d;
            bit perr, glitch;
            if (rstv[p - 1] || rsv(p - 1)) begin
                p++;
                continue;
            end
            s0 = p + HALF;
            sp = s0 + 9 * DIV;
            ss = s0 + STOP_K * DIV;
            glitch = rsv(s0 - 1);
            d = '0;
            perr = 1'b0;
            for (int b = 0; b < 8; b++) d[b] = rsv(s0 + (b + 1) * DIV - 1);
            if (STOP_K == 10) perr = (rsv(sp - 1) != ((^d) ^ ODD));
            if (glitch) e = s0;
            else if (rsv(ss - 1)) e = ss;
            else begin
                e = ss + 1;
                while (e < N - 1 && !rsv(e - 1)) e++;
            end
            x = 0;
            for (int q = p + 1; q <= e && x == 0; q++) if (rstv[q - 1]) x = q;
            stop_at = (x != 0) ? x : e;
            if (!glitch) begin
                if (STOP_K == 10 && perr && (x == 0 || x > sp)) ev_p[sp] = 1'b1;
                if (x == 0 || x > ss) begin
                    if (rsv(ss - 1)) begin
                        if (!perr) begin
                            ev_b[ss] = 1'b1;
                            ev_d[ss] = d;
                        end
                    end else begin
                        ev_f[ss] = 1'b1;
                    end
                end
            end
            for (int c = p; c < stop_at; c++) bz[c] = 1'b1;
            p = stop_at + 1;
        end
    endtask

    // Driver and final literal checks.
    initial begin
        build();
        run_model();
        rxd = ln[0]; reset = rstv[0]; rx_ready = rd[0]; err_clr = cl[0];
        for (int k = 1; k < N; k++) begin
            @(posedge clk);
            #1;
            rxd = ln[k]; reset = rstv[k]; rx_ready = rd[k]; err_clr = cl[k];
        end
        @(negedge clk);

        chk("reset busy",      ob_busy[5], 0);
        chk("reset valid",     ob_vld[5], 0);
        chk("reset data",      ob_data[5], 8'h00);
        chk("reset flags",     {ob_ferr[5], ob_ovr[5]}, 0);
        chk("A5 model event",  {ev_b[T1 + LAT], ev_d[T1 + LAT]}, {1'b1, 8'hA5});
        chk("A5 early valid",  ob_vld[T1 + LAT - 1], 0);
        chk("A5 valid",        ob_vld[T1 + LAT], 1);
        chk("A5 data",         ob_data[T1 + LAT], 8'hA5);
        chk("A5 one pulse",    ob_vld[T1 + LAT + 1], 0);
        chk("ovr data kept",   ob_data[T2 + FL + LAT], 8'h3C);
        chk("ovr before",      ob_ovr[T2 + FL + LAT - 1], 0);
        chk("ovr set",         ob_ovr[T2 + FL + LAT], 1);
        chk("ovr valid held",  ob_vld[X], 1);
        chk("ovr consumed",    ob_vld[X + 1], 0);
        chk("ovr sticky",      ob_ovr[X + 5], 1);
        chk("ovr cleared",     ob_ovr[X + 6], 0);
        chk("ferr set",        ob_ferr[T4 + LAT], 1);
        chk("ferr no valid",   ob_vld[T4 + LAT], 0);
        begin
            int mev, rises;
            mev = 0;
            rises = 0;
            for (int c = T4; c < T4b; c++) begin
                mev += ev_f[c];
                if (ob_ferr[c] && !ob_ferr[c - 1]) rises++;
            end
            chk("ferr model count", mev, 1);
            chk("ferr rise count",  rises, 1);
        end
        chk("break busy",      ob_busy[H + 2], 1);
        chk("break released",  ob_busy[H + 3], 0);
        chk("0F data",         ob_data[T4b + LAT], 8'h0F);
        chk("0F valid",        ob_vld[T4b + LAT], 1);
        chk("glitch busy",     ob_busy[T5 + 3], 1);
        chk("glitch idle",     ob_busy[T5 + 11], 0);
        chk("reset mid busy",  ob_busy[T6 + 5 * DIV], 1);
        chk("reset mid idle",  ob_busy[T6 + 5 * DIV + 1], 0);
        chk("reset mid data",  ob_data[T6 + 5 * DIV + 1], 8'h00);
        chk("reset mid ferr",  ob_ferr[T6 + 5 * DIV + 1], 0);
        chk("81 data",         ob_data[T6b + LAT], 8'h81);
        chk("81 valid",        ob_vld[T6b + LAT], 1);
`ifdef SER_RX_PARITY_EN
        chk("perr before",     ob_perr[TP + 3 + HALF + 9 * DIV - 1], 0);
        chk("perr set",        ob_perr[TP + 3 + HALF + 9 * DIV], 1);
        chk("perr no valid",   ob_vld[TP + LAT], 0);
        chk("par ok data",     ob_data[TP2 + LAT], 8'h07);
        chk("par ok valid",    ob_vld[TP2 + LAT], 1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Every-cycle comparison against the handshake/flag rules driven by model events.
    initial begin
        bit         e_vld, e_ovr, e_ferr, e_perr, old_vld;
        logic [7:0] e_data;
        e_vld = 0; e_ovr = 0; e_ferr = 0; e_perr = 0; e_data = 8'h00;
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < N) begin
                int c;
                bit ok;
                c = cyc;
                if (rstv[c - 1]) begin
                    e_vld = 0; e_ovr = 0; e_ferr = 0; e_perr = 0; e_data = 8'h00;
                end else begin
                    old_vld = e_vld;
                    if (ev_b[c] && (!old_vld || rd[c - 1])) begin
                        e_data = ev_d[c];
                        e_vld  = 1;
                    end else if (old_vld && rd[c - 1]) begin
                        e_vld = 0;
                    end
                    if (ev_b[c] && old_vld && !rd[c - 1]) e_ovr = 1;
                    else if (cl[c - 1])                   e_ovr = 0;
                    if (ev_f[c])        e_ferr = 1;
                    else if (cl[c - 1]) e_ferr = 0;
                    if (ev_p[c])        e_perr = 1;
                    else if (cl[c - 1]) e_perr = 0;
                end
                ob_data[c] = rx_data;
                ob_vld[c]  = rx_valid;
                ob_ovr[c]  = overrun_err;
                ob_ferr[c] = frame_err;
                ob_busy[c] = busy;
`ifdef SER_RX_PARITY_EN
                ob_perr[c] = parity_err;
`else
                ob_perr[c] = 1'b0;
`endif
                ok = (rx_valid === e_vld) && (rx_data === e_data) && (overrun_err === e_ovr) &&
                     (frame_err === e_ferr) && (busy === bz[c]) && (ob_perr[c] === e_perr);
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL cycle %0d: got vld %0b data %02h ovr %0b ferr %0b busy %0b perr %0b, expected %0b %02h %0b %0b %0b %0b",
                             c, rx_valid, rx_data, overrun_err, frame_err, busy, ob_perr[c],
                             e_vld, e_data, e_ovr, e_ferr, bz[c], e_perr);
                end
            end
        end
    end

endmodule
